pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised pipeline stage register: generalised successor of the fixed 96-bit IF/ID latch.
//  Carries a payload between two pipeline stages with a valid/ready handshake.
//  A 2-entry skid buffer keeps full throughput with no combinational ready path.
//  Supports a hard flush (e.g. branch taken) and per-source kills of the incoming word (e.g. jumps).
//  Inserts zero-payload bubbles (NOP) wherever the stage is empty.
// PARAMETERS
//  DATA_W     96  payload width in bits
//  KILL_SRCS  2   number of independent kill-incoming request bits
//  CNT_W      16  width of each performance counter (PIPE_STAGE_PERF_EN only)
// PORTS
//  Clk        in   1          rising-edge clock
//  Reset_n    in   1          asynchronous, active-low reset
//  in_valid   in   1          upstream word valid
//  in_ready   out  1          stage can accept a word
//  in_data    in   DATA_W     upstream payload
//  kill_in    in   KILL_SRCS  any bit set: accepted word this cycle is discarded
//  flush      in   1          hard flush: empty the stage
//  out_valid  out  1          downstream word valid
//  out_ready  in   1          downstream accepts
//  out_data   out  DATA_W     downstream payload; 0 whenever out_valid=0
//  perf_clr   in   1          sync clear of counters (PIPE_STAGE_PERF_EN only)
//  stall_cnt  out  CNT_W      cycles with out_valid & ~out_ready (PIPE_STAGE_PERF_EN only)
//  flush_cnt  out  CNT_W      cycles with flush=1 (PIPE_STAGE_PERF_EN only)
//  kill_cnt   out  CNT_W      words discarded by kill_in (PIPE_STAGE_PERF_EN only)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): state EMPTY; out_valid=0, out_data=0, in_ready=1; counters=0.
//  - Storage: main reg drives out_*; skid reg holds one overflow word.
//  - acc = in_valid & in_ready; push = acc & ~|kill_in & ~flush; pop = out_valid & out_ready.
//  - States: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
//  - EMPTY: push -> ONE, main<=in_data.
//  - ONE: push&pop -> ONE, main<=in_data; push&~pop -> FULL, skid<=in_data;
//    ~push&pop -> EMPTY, main data<=0; otherwise hold.
//  - FULL: pop -> ONE, main<=skid; otherwise hold. No push is possible (in_ready=0).
//  - in_ready = (state != FULL); decoded from state registers only,
//    with no combinational path from out_ready, flush or kill_in.
//  - Latency: accept at cycle N -> out_valid at N+1. Sustained throughput: 1 word/cycle.
//  - Kill: the handshake still completes (upstream sees the word consumed).
//    The word is dropped and the state updates as for ~push; a pop in the same cycle still happens.
//  - Flush (highest priority): next state EMPTY, main data<=0, skid dropped.
//    This applies regardless of push/pop/kill that cycle.
//    A pop in the flush cycle is still a valid downstream transfer.
//  - Invariant: out_valid=0 implies out_data=0 (bubble = all-zero NOP).
//  - Output values hold while out_valid & ~out_ready.
//  - Reset asserted mid-transfer: immediate EMPTY; in-flight words are lost.
// CONFIGURATION
//  - PIPE_STAGE_PERF_EN defined: perf_clr, stall_cnt, flush_cnt and kill_cnt ports exist.
//    Counters saturate at all-ones and never wrap.
//    perf_clr has priority over increment; cleared value is visible the next cycle.
//    kill_cnt increments by 1 per killed acc, independent of how many kill bits are set.
//  - Macro undefined: the counter ports and logic are absent; handshake behaviour is identical.
// TESTING
//  1. Reset, then in_valid=1 with data 0x1..0x8 and out_ready=1
//     -> out_data 0x1..0x8 one per cycle, starting 1 cycle later; in_ready stays 1.
//  2. Stream 0xA,0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA held;
//     out_ready=1 -> 0xA then 0xB out; in_ready=1 one cycle after the first pop.
//  3. FULL (0xA,0xB) with flush=1 for one cycle -> next cycle out_valid=0, out_data=0, in_ready=1;
//     a following push of 0xC appears alone.
//  4. Push 0x5 with kill_in=2'b10 -> in_ready=1, no out_valid next cycle;
//     repeat with kill_in=0 -> 0x5 appears.
//  5. Reset_n low mid-stream between clock edges -> out_valid=0 and out_data=0 immediately;
//     no stale word after release.
//  6. (PIPE_STAGE_PERF_EN, CNT_W=4) 20 stall cycles -> stall_cnt=15 (saturated);
//     perf_clr=1 -> 0 the next cycle; 3 killed words -> kill_cnt=3.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Parametrised pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. This is the generalised successor of the fixed 96-bit
// IF/ID latch.
//
// The main register drives the outputs. The skid register holds one overflow
// word, so in_ready_o depends only on the state register. Throughput is one
// word per cycle.
//
// Control inputs:
//   - flush_i empties the stage (for example, a taken branch).
//   - Any bit of kill_in_i drops the word accepted in that cycle (for example,
//     jumps).
//
// When the stage is empty, the output is an all-zero bubble (NOP).
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, saturating performance counters and their ports are added.
//
// Ports:
//   clk_i        in   1          rising-edge clock
//   rst_ni       in   1          asynchronous, active-low reset
//   in_valid_i   in   1          upstream word valid
//   in_ready_o   out  1          stage can accept a word
//   in_data_i    in   DATA_W     upstream payload
//   kill_in_i    in   KILL_SRCS  any bit set: word accepted this cycle dropped
//   flush_i      in   1          hard flush: empty the stage
//   out_valid_o  out  1          downstream word valid
//   out_ready_i  in   1          downstream accepts
//   out_data_o   out  DATA_W     downstream payload, zero when not valid
//   perf_clr_i   in   1          sync clear of counters      (PIPE_STAGE_PERF_EN)
//   stall_cnt_o  out  CNT_W      cycles valid & not ready     (PIPE_STAGE_PERF_EN)
//   flush_cnt_o  out  CNT_W      cycles with flush asserted   (PIPE_STAGE_PERF_EN)
//   kill_cnt_o   out  CNT_W      words discarded by kill_in_i (PIPE_STAGE_PERF_EN)
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int DATA_W    = 96,
    parameter int KILL_SRCS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_W-1:0]    in_data_i,
    input  logic [KILL_SRCS-1:0] kill_in_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    out_data_o
`ifdef PIPE_STAGE_PERF_EN
   ,input  logic                 perf_clr_i,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o,
    output logic [CNT_W-1:0]     kill_cnt_o
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic acc;
    logic killed;
    logic push;
    logic pop;

    // Ready and valid are decoded from the state register only.
    // This keeps out_ready_i, flush_i and kill_in_i off the ready path.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;

    assign acc    = in_valid_i & in_ready_o;
    assign killed = |kill_in_i;
    assign push   = acc & ~killed & ~flush_i;
    assign pop    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // A flush wins over everything else.
            // A pop in this cycle has already been seen downstream.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data_i;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        // Zero the main register so an empty stage shows a NOP.
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q,  kill_cnt_d;

    // Counters saturate at all-ones.
    // A clear takes priority over any increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            kill_cnt_d  = '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
            if (acc && killed && (kill_cnt_q != '1)) begin
                kill_cnt_d = kill_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Self-checking bench for pipe_stage_skid_reg. It uses two independent
// checkers:
//   - A table of per-cycle vectors, each with hand-derived expected outputs.
//   - A queue scoreboard. Words accepted without a kill are pushed, a flush
//     clears the queue, and every downstream transfer pops and compares.
//
// Hand-written sequences cover mid-cycle reset and, when PIPE_STAGE_PERF_EN
// is defined, the saturating counters (built with CNT_W=4).
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

    localparam int DATA_W    = 96;
    localparam int KILL_SRCS = 2;
    localparam int CNT_W     = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [KILL_SRCS-1:0] kill_in;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 perf_clr;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]     kill_cnt;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] sbQueue[$];

    pipe_stage_skid_reg #(
        .DATA_W   (DATA_W),
        .KILL_SRCS(KILL_SRCS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .kill_in_i  (kill_in),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
`ifdef PIPE_STAGE_PERF_EN
       ,.perf_clr_i (perf_clr),
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt),
        .kill_cnt_o (kill_cnt)
`endif
    );

`ifndef PIPE_STAGE_PERF_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign kill_cnt  = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 v;
        logic [DATA_W-1:0]    d;
        logic [KILL_SRCS-1:0] k;
        logic                 f;
        logic                 r;
        logic                 expValid;
        logic [DATA_W-1:0]    expData;
        logic                 expReady;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input logic [127:0] actual,
                            input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard view of the outputs, sampled at the negative edge.
    // A downstream transfer is where the queue head is compared.
    task automatic checkOutput(input string tag);
        logic [DATA_W-1:0] head;
        head = (sbQueue.size() > 0) ? sbQueue[0] : '0;
        checkVal({tag, " sb out_valid"}, 128'(out_valid), 128'(sbQueue.size() > 0));
        checkVal({tag, " sb in_ready"}, 128'(in_ready), 128'(sbQueue.size() < 2));
        checkVal({tag, " sb out_data"}, 128'(out_data), 128'(head));
    endtask

    // Drives one cycle of inputs, then waits for the negative edge to sample.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic [KILL_SRCS-1:0] k, input logic f,
                                 input logic r);
        in_valid  = v;
        in_data   = d;
        kill_in   = k;
        flush     = f;
        out_ready = r;
        @(negedge clk);
    endtask

    // Advances through the rising edge and updates the scoreboard from the
    // inputs that edge consumed.
    task automatic clockEdge();
        logic acc;
        logic pop;
        acc = in_valid && (sbQueue.size() < 2);
        pop = (sbQueue.size() > 0) && out_ready;
        @(posedge clk);
        if (pop) void'(sbQueue.pop_front());
        if (flush) sbQueue.delete();
        else if (acc && (kill_in == '0)) sbQueue.push_back(in_data);
        #1;
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic [KILL_SRCS-1:0] k, input logic f,
                        input logic r, input string tag);
        applyStimulus(v, d, k, f, r);
        checkOutput(tag);
        clockEdge();
    endtask

    task automatic addVec(input logic v, input logic [DATA_W-1:0] d,
                          input logic [KILL_SRCS-1:0] k, input logic f,
                          input logic r, input logic ev,
                          input logic [DATA_W-1:0] ed, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.k = k; t.f = f; t.r = r;
        t.expValid = ev; t.expData = ed; t.expReady = er;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        kill_in   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        perf_clr  = 1'b0;

        // Expected values are the outputs seen before each cycle's rising
        // edge: v, d, k, f, r, then expected out_valid, out_data, in_ready.
        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++)
            addVec(1, DATA_W'(i), 0, 0, 1, (i > 1), (i > 1) ? DATA_W'(i - 1) : '0, 1);
        addVec(0, 0, 0, 0, 1, 1, 'h8, 1);
        // Backpressure fills the skid register, then drains.
        addVec(1, 'hA, 0, 0, 0, 0, 'h0, 1);
        addVec(1, 'hB, 0, 0, 0, 1, 'hA, 1);
        addVec(0, 0,   0, 0, 0, 1, 'hA, 0);
        addVec(0, 0,   0, 0, 1, 1, 'hA, 0);
        addVec(0, 0,   0, 0, 1, 1, 'hB, 1);
        addVec(0, 0,   0, 0, 1, 0, 'h0, 1);
        // Flush while FULL, then a lone word 0xC.
        addVec(1, 'hA, 0, 0, 0, 0, 'h0, 1);
        addVec(1, 'hB, 0, 0, 0, 1, 'hA, 1);
        addVec(0, 0,   0, 1, 0, 1, 'hA, 0);
        addVec(1, 'hC, 0, 0, 1, 0, 'h0, 1);
        addVec(0, 0,   0, 0, 1, 1, 'hC, 1);
        addVec(0, 0,   0, 0, 1, 0, 'h0, 1);
        // Killed word, then the same word without a kill.
        addVec(1, 'h5, 2'b10, 0, 1, 0, 'h0, 1);
        addVec(0, 0,   0,     0, 1, 0, 'h0, 1);
        addVec(1, 'h5, 0,     0, 1, 0, 'h0, 1);
        addVec(0, 0,   0,     0, 1, 1, 'h5, 1);
        addVec(0, 0,   0,     0, 1, 0, 'h0, 1);
        // A kill in the same cycle as a pop: 6 leaves, 7 is dropped.
        addVec(1, 'h6, 0,     0, 1, 0, 'h0, 1);
        addVec(1, 'h7, 2'b01, 0, 1, 1, 'h6, 1);
        addVec(0, 0,   0,     0, 1, 0, 'h0, 1);
        // A flush in the same cycle as a pop: 9 leaves, E is dropped.
        addVec(1, 'h9, 0, 0, 1, 0, 'h0, 1);
        addVec(1, 'hE, 0, 1, 1, 1, 'h9, 1);
        addVec(0, 0,   0, 0, 1, 0, 'h0, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset out_valid", 128'(out_valid), 128'(0));
        checkVal("reset out_data", 128'(out_data), 128'(0));
        checkVal("reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].f, vecs[i].r);
            checkVal($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].expValid));
            checkVal($sformatf("vec%0d out_data", i), 128'(out_data), 128'(vecs[i].expData));
            checkVal($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d", i));
            clockEdge();
        end

        // Reset asserted between clock edges while the stage is FULL.
        step(1, 'h21, 0, 0, 0, "rst fill0");
        step(1, 'h22, 0, 0, 0, "rst fill1");
        checkVal("pre-reset in_ready", 128'(in_ready), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async reset out_valid", 128'(out_valid), 128'(0));
        checkVal("async reset out_data", 128'(out_data), 128'(0));
        checkVal("async reset in_ready", 128'(in_ready), 128'(1));
        sbQueue.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1, "post-reset idle0");
        step(0, 0, 0, 0, 1, "post-reset idle1");
        step(1, 'h3, 0, 0, 1, "post-reset push");
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("post-reset word", 128'(out_data), 128'('h3));
        checkOutput("post-reset out");
        clockEdge();
        step(0, 0, 0, 0, 1, "post-reset drain");

`ifdef PIPE_STAGE_PERF_EN
        // Counters: clear, saturate stall, clear again, then kills and flush.
        perf_clr = 1'b1;
        step(0, 0, 0, 0, 1, "perf clr0");
        perf_clr = 1'b0;
        applyStimulus(1, 'h11, 0, 0, 0);
        checkVal("perf cleared stall", 128'(stall_cnt), 128'(0));
        checkVal("perf cleared flush", 128'(flush_cnt), 128'(0));
        checkVal("perf cleared kill", 128'(kill_cnt), 128'(0));
        checkOutput("perf load");
        clockEdge();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, "perf stall");
        perf_clr = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("stall_cnt saturated", 128'(stall_cnt), 128'(15));
        checkOutput("perf clr1");
        clockEdge();
        perf_clr = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("stall_cnt after clr", 128'(stall_cnt), 128'(0));
        checkOutput("perf post clr");
        clockEdge();
        step(1, 'h31, 2'b11, 0, 1, "perf kill0");
        step(1, 'h32, 2'b01, 0, 1, "perf kill1");
        step(1, 'h33, 2'b10, 0, 1, "perf kill2");
        applyStimulus(0, 0, 0, 1, 1);
        checkVal("kill_cnt three", 128'(kill_cnt), 128'(3));
        checkOutput("perf flush");
        clockEdge();
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("flush_cnt one", 128'(flush_cnt), 128'(1));
        checkVal("stall_cnt idle", 128'(stall_cnt), 128'(0));
        clockEdge();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run; the main sequence needs far fewer cycles.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
